// File: rtl/aes_core_sequencer.sv
// Initiator-side sequencer for aes_core. It accepts one block request, runs key expansion
// only when the loaded key cannot be reused, runs block processing, and returns the result.
module aes_core_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LAT_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_encdec,
    input  logic               req_keylen,
    input  logic               req_new_key,
    input  logic [255:0]       req_key,
    input  logic [127:0]       req_block,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [127:0]       rsp_data,
    output logic               rsp_error,
    output logic [LAT_W-1:0]   last_latency,
    output logic               core_encdec,
    output logic               core_init,
    output logic               core_next,
    output logic               core_keylen,
    output logic [255:0]       core_key,
    output logic [127:0]       core_block,
    input  logic               core_ready,
    input  logic [127:0]       core_result,
    input  logic               core_result_valid
);

    typedef enum logic [2:0] {
        IDLE,
        KEY_INIT,
        KEY_WAIT,
        BLK_START,
        BLK_WAIT,
        RESP
    } state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic              key_valid;
    logic              loaded_keylen;
    logic              encdec_q;
    logic              keylen_q;
    logic [255:0]      key_q;
    logic [127:0]      block_q;
    logic [WD_W-1:0]   wd_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [LAT_W-1:0]  lat_inc;
    logic              need_init;
    logic              guard_done;
    logic              wd_fire;

    // Reuse is decided on control inputs only; the key value itself is never compared.
    assign need_init  = req_new_key || !key_valid || (req_keylen != loaded_keylen);
    assign lat_inc    = (&lat_cnt) ? lat_cnt : lat_cnt + LAT_W'(1);
    assign guard_done = (wd_cnt != '0);
    assign wd_fire    = (wd_cnt == WD_LAST);

    assign core_encdec = encdec_q;
    assign core_keylen = keylen_q;
    assign core_key    = key_q;
    assign core_block  = block_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_error     <= 1'b0;
            rsp_data      <= '0;
            last_latency  <= '0;
            core_init     <= 1'b0;
            core_next     <= 1'b0;
            encdec_q      <= 1'b0;
            keylen_q      <= 1'b0;
            key_q         <= '0;
            block_q       <= '0;
            key_valid     <= 1'b0;
            loaded_keylen <= 1'b0;
            wd_cnt        <= '0;
            lat_cnt       <= '0;
        end else begin
            core_init <= 1'b0;
            core_next <= 1'b0;
            if (state != IDLE) begin
                lat_cnt <= lat_inc;
            end

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        encdec_q  <= req_encdec;
                        keylen_q  <= req_keylen;
                        key_q     <= req_key;
                        block_q   <= req_block;
                        lat_cnt   <= '0;
                        req_ready <= 1'b0;
                        state     <= need_init ? KEY_INIT : BLK_START;
                    end
                end

                KEY_INIT: begin
                    if (core_ready) begin
                        core_init <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= KEY_WAIT;
                    end
                end

                // The first wait cycle samples core_ready before the core has seen the
                // pulse, so completion is only accepted once wd_cnt has moved off zero.
                KEY_WAIT: begin
                    if (guard_done && core_ready) begin
                        key_valid     <= 1'b1;
                        loaded_keylen <= keylen_q;
                        state         <= BLK_START;
                    end else if (wd_fire) begin
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b1;
                        rsp_data     <= '0;
                        key_valid    <= 1'b0;
                        last_latency <= lat_inc;
                        state        <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                BLK_START: begin
                    if (core_ready) begin
                        core_next <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= BLK_WAIT;
                    end
                end

                BLK_WAIT: begin
                    if (guard_done && core_ready && core_result_valid) begin
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b0;
                        rsp_data     <= core_result;
                        last_latency <= lat_inc;
                        state        <= RESP;
                    end else if (wd_fire) begin
                        rsp_valid    <= 1'b1;
                        rsp_error    <= 1'b1;
                        rsp_data     <= '0;
                        key_valid    <= 1'b0;
                        last_latency <= lat_inc;
                        state        <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                // Response is held until taken; req_ready reopens on the following cycle.
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_error <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Bench for aes_core_sequencer: a behavioural aes_core stand-in, a request driver with a
// key-reuse reference model, and a monitor that scores every response against a queue.
module tb_aes_core_sequencer;

    localparam int TO = 16;
    localparam int LW = 4;
    localparam logic [127:0] K128_HI = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K128    = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_encdec, req_keylen, req_new_key;
    logic [255:0]   req_key;
    logic [127:0]   req_block;
    logic           rsp_valid, rsp_ready, rsp_error;
    logic [127:0]   rsp_data;
    logic [LW-1:0]  last_latency;
    logic           core_encdec, core_init, core_next, core_keylen;
    logic [255:0]   core_key;
    logic [127:0]   core_block;
    logic           core_ready, core_result_valid;
    logic [127:0]   core_result;

    always #5 clk = ~clk;

    aes_core_sequencer #(.TIMEOUT_CYCLES(TO), .LAT_W(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_encdec(req_encdec),
        .req_keylen(req_keylen), .req_new_key(req_new_key), .req_key(req_key),
        .req_block(req_block),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .last_latency(last_latency),
        .core_encdec(core_encdec), .core_init(core_init), .core_next(core_next),
        .core_keylen(core_keylen), .core_key(core_key), .core_block(core_block),
        .core_ready(core_ready), .core_result(core_result),
        .core_result_valid(core_result_valid)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         err;
        logic [1:0]   n_init;
        logic [1:0]   n_next;
        logic         faster;
        logic [31:0]  acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Driver-owned knobs read by the core stand-in and the response sink.
    int   busy_lo, busy_hi;
    logic lazy_en, stuck, bp_mode, faster;

    // Core transfer function: FIPS-197 vectors where known, a keyed mix elsewhere.
    function automatic logic [127:0] core_fn(input logic [255:0] key, input logic kl,
                                             input logic enc, input logic [127:0] blk);
        logic [127:0] k;
        if (!kl && key[255:128] == K128_HI && enc && blk == PT) return CT128;
        if (!kl && key[255:128] == K128_HI && !enc && blk == CT128) return PT;
        if (kl && key == K256 && enc && blk == PT) return CT256;
        if (kl && key == K256 && !enc && blk == CT256) return PT;
        k = key[255:128] ^ (kl ? {key[63:0], key[127:64]} : 128'h0);
        return enc ? ((blk ^ k) + 128'd1) : ({blk[63:0], blk[127:64]} ^ ~k);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Core stand-in: drops ready after a pulse (optionally one cycle late), stays busy a
    // random time, and computes results with the key latched at the last init.
    initial begin
        int           op;
        int           busy;
        logic         hold;
        logic [255:0] s_key;
        logic         s_kl, s_enc;
        logic [127:0] s_blk;
        op = 0; busy = 0; hold = 0;
        s_key = '0; s_kl = 0; s_enc = 0; s_blk = '0;
        core_ready = 1'b1; core_result_valid = 1'b0; core_result = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                core_ready = 1'b1; core_result_valid = 1'b0;
                op = 0; busy = 0; hold = 0;
                continue;
            end
            if (core_init || core_next) begin
                chk("pulse_while_core_busy", 128'(op), 128'(0));
                if (core_init) begin
                    s_key = core_key; s_kl = core_keylen; op = 1;
                end else begin
                    s_enc = core_encdec; s_blk = core_block; op = 2;
                end
                busy = $urandom_range(busy_hi, busy_lo);
                if (lazy_en && $urandom_range(0, 1) == 1) begin
                    hold = 1'b1;
                end else begin
                    core_ready = 1'b0;
                    if (op == 2) core_result_valid = 1'b0;
                end
            end else if (hold) begin
                hold = 1'b0;
                core_ready = 1'b0;
                if (op == 2) core_result_valid = 1'b0;
            end else if (op != 0 && !(stuck && op == 1)) begin
                if (busy > 0) begin
                    busy--;
                end else begin
                    core_ready = 1'b1;
                    if (op == 2) begin
                        core_result_valid = 1'b1;
                        core_result = core_fn(s_key, s_kl, s_enc, s_blk);
                    end
                    op = 0;
                end
            end
        end
    end

    // Response sink: random acceptance, or a 20-cycle hold when bp_mode is set.
    initial begin
        int bp_n;
        bp_n = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bp_mode) begin
                if (rsp_valid) bp_n++;
                rsp_ready = (bp_n > 20);
            end else begin
                bp_n = 0;
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: protocol invariants every cycle, scoreboard compare on each new response.
    initial begin
        int            n_init, n_next, init_edge, lat, lat_exp;
        logic          prev_rv, prev_err, prev_init;
        logic [127:0]  prev_data;
        logic [LW-1:0] prev_lat;
        exp_t          e;
        n_init = 0; n_next = 0; init_edge = 0;
        prev_rv = 0; prev_err = 0; prev_init = 0; prev_data = '0; prev_lat = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (reset) begin
                chk("rst_req_ready", 128'(req_ready), 128'(1));
                chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
                chk("rst_rsp_error", 128'(rsp_error), 128'(0));
                chk("rst_pulses", 128'({core_init, core_next}), 128'(0));
                chk("rst_rsp_data", rsp_data, 128'(0));
                chk("rst_last_latency", 128'(last_latency), 128'(0));
                chk("rst_core_key_hi", core_key[255:128], 128'(0));
                chk("rst_core_key_lo", core_key[127:0], 128'(0));
                chk("rst_core_block", core_block, 128'(0));
                chk("rst_core_ctl", 128'({core_encdec, core_keylen}), 128'(0));
                exp_q.delete();
                n_init = 0; n_next = 0;
                prev_rv = 0; prev_err = 0; prev_init = 0; prev_data = '0;
                continue;
            end
            if (core_init && core_next) chk("init_next_together", 128'(1), 128'(0));
            if (core_init) begin
                chk("init_single_cycle", 128'(prev_init), 128'(0));
                n_init++;
                init_edge = cyc;
            end
            if (core_next) n_next++;
            if (rsp_valid) begin
                chk("pulse_during_resp", 128'({core_init, core_next}), 128'(0));
                chk("req_ready_during_resp", 128'(req_ready), 128'(0));
            end
            if (prev_rv && !rsp_ready) begin
                chk("hold_rsp_valid", 128'(rsp_valid), 128'(1));
                chk("hold_rsp_data", rsp_data, prev_data);
                chk("hold_rsp_error", 128'(rsp_error), 128'(prev_err));
            end
            if (prev_rv && rsp_ready) begin
                chk("post_hs_req_ready", 128'(req_ready), 128'(1));
                chk("post_hs_rsp_valid", 128'(rsp_valid), 128'(0));
            end
            if (rsp_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    lat = cyc - int'(e.acc);
                    lat_exp = (lat > 15) ? 15 : lat;
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_error", 128'(rsp_error), 128'(e.err));
                    chk("init_pulses", 128'(n_init), 128'(e.n_init));
                    chk("next_pulses", 128'(n_next), 128'(e.n_next));
                    chk("last_latency", 128'(last_latency), 128'(lat_exp));
                    if (e.err) chk("watchdog_cycles", 128'(cyc - init_edge), 128'(TO));
                    if (e.faster) chk("reuse_faster", 128'(last_latency < prev_lat), 128'(1));
                    prev_lat = last_latency;
                end
                n_init = 0; n_next = 0;
            end
            prev_rv = rsp_valid; prev_err = rsp_error; prev_data = rsp_data; prev_init = core_init;
        end
    end

    // Reference model of the loaded key as seen by the core.
    logic         m_kv, m_kl;
    logic [255:0] m_key;

    task automatic send(input logic enc, input logic kl, input logic nk,
                        input logic [255:0] key, input logic [127:0] blk, input logic err);
        exp_t e;
        logic need;
        int   n;
        @(negedge clk);
        req_valid = 1'b1; req_encdec = enc; req_keylen = kl; req_new_key = nk;
        req_key = key; req_block = blk;
        n = 0;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 128'(0), 128'(1));
            req_valid = 1'b0;
            return;
        end
        need = nk || !m_kv || (kl != m_kl);
        if (need) begin
            m_key = key; m_kl = kl;
        end
        e.n_init = need ? 2'd1 : 2'd0;
        if (err) begin
            e.data = '0; e.err = 1'b1; e.n_next = 2'd0; m_kv = 1'b0;
        end else begin
            e.data = core_fn(m_key, m_kl, enc, blk); e.err = 1'b0; e.n_next = 2'd1; m_kv = 1'b1;
        end
        e.faster = faster;
        e.acc = 32'(cyc + 1);
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0; req_key = rand256(); req_block = rand128();
        req_new_key = $urandom_range(0, 1); req_keylen = $urandom_range(0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!req_ready || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("idle_timeout", 128'(0), 128'(1));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_kv = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_encdec = 0; req_keylen = 0; req_new_key = 0;
        req_key = '0; req_block = '0;
        busy_lo = 3; busy_hi = 3; lazy_en = 0; stuck = 0; bp_mode = 0; faster = 0;
        m_kv = 0; m_kl = 0; m_key = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        send(1'b1, 1'b0, 1'b1, K128, PT, 1'b0);
        send(1'b1, 1'b1, 1'b1, K256, PT, 1'b0);
        faster = 1'b1;
        send(1'b0, 1'b1, 1'b0, K256, CT256, 1'b0);
        faster = 1'b0;
        send(1'b1, 1'b0, 1'b0, K128, PT, 1'b0);
        wait_idle();

        bp_mode = 1'b1;
        send(1'b1, 1'b1, 1'b0, rand256(), rand128(), 1'b0);
        wait_idle();
        bp_mode = 1'b0;

        stuck = 1'b1;
        send(1'b1, 1'b0, 1'b1, rand256(), rand128(), 1'b1);
        wait_idle();
        stuck = 1'b0;
        send(1'b0, 1'b0, 1'b0, K128, CT128, 1'b0);
        wait_idle();

        send(1'b1, 1'b0, 1'b0, K128, PT, 1'b0);
        n = 0;
        while (!core_next && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!core_next) chk("next_pulse_timeout", 128'(0), 128'(1));
        pulse_reset();
        send(1'b1, 1'b0, 1'b0, K128, PT, 1'b0);
        wait_idle();

        busy_lo = 0; busy_hi = 8; lazy_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                 rand256(), ($urandom_range(0, 3) == 0) ? PT : rand128(), 1'b0);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
